// File: rtl/wave_osc.sv
// Runtime-tunable DDS oscillator: saw, square, triangle or sine on a valid/ready stream.
// Optional WAVE_OSC_PWM_EN adds a pw_i duty threshold for the square wave.
module wave_osc #(
  parameter int width_p       = 12,
  parameter int phase_width_p = 24,
  parameter int lut_log2_p    = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [phase_width_p-1:0] freq_i,
  input  logic [1:0]               mode_i,
  input  logic                     sync_i,
  input  logic                     ready_i,
`ifdef WAVE_OSC_PWM_EN
  input  logic [width_p-1:0]       pw_i,
`endif
  output logic [width_p-1:0]       data_o,
  output logic                     valid_o
);

  // state    | meaning
  // ST_IDLE  | in or just out of reset; next edge loads wave(0) and raises valid
  // ST_RUN   | streaming; phase advances on each valid && ready handshake
  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  localparam int  rom_depth_c = 2 ** lut_log2_p;
  localparam real pi_c        = 3.14159265358979323846;
  localparam real amp_c       = real'(2 ** (width_p - 1) - 1);
  localparam logic [width_p-1:0] pos_full_c = {1'b0, {(width_p-1){1'b1}}};
  localparam logic [width_p-1:0] neg_full_c = {1'b1, {(width_p-1){1'b0}}};

  state_t                   state_q, state_d;
  logic [phase_width_p-1:0] phase;
  logic [phase_width_p-1:0] wave_phase;
  logic                     load_zero;
  logic                     advance;
  logic [width_p-1:0]       p;
  logic [width_p-1:0]       u;
  logic [width_p-1:0]       t;
  logic                     msb;
  logic [width_p-1:0]       sample;
  logic [width_p-1:0]       sine_rom [rom_depth_c];

  // Sine table is fixed at elaboration, rounded half away from zero.
  for (genvar k = 0; k < rom_depth_c; k++) begin : g_rom
    localparam real    ang_c = (2.0 * pi_c * k) / rom_depth_c;
    localparam real    val_c = amp_c * $sin(ang_c);
    localparam integer int_c = (val_c >= 0.0) ? $rtoi(val_c + 0.5) : $rtoi(val_c - 0.5);
    assign sine_rom[k] = width_p'(int_c);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    load_zero = 1'b0;
    advance   = 1'b0;
    valid_o   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        load_zero = 1'b1;
        state_d   = ST_RUN;
      end
      ST_RUN: begin
        valid_o   = 1'b1;
        load_zero = sync_i;
        advance   = ready_i;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign wave_phase = load_zero ? '0 : phase + freq_i;
  assign msb        = wave_phase[phase_width_p-1];
  assign p          = wave_phase[phase_width_p-1 -: width_p];
  assign u          = wave_phase[phase_width_p-2 -: width_p];
  assign t          = msb ? ~u : u;

  always_comb begin
    sample = '0;
    case (mode_i)
      2'd0: sample = {~p[width_p-1], p[width_p-2:0]};
`ifdef WAVE_OSC_PWM_EN
      2'd1: sample = (p < pw_i) ? pos_full_c : neg_full_c;
`else
      2'd1: sample = msb ? neg_full_c : pos_full_c;
`endif
      2'd2: sample = {~t[width_p-1], t[width_p-2:0]};
      2'd3: sample = sine_rom[wave_phase[phase_width_p-1 -: lut_log2_p]];
      default: sample = '0;
    endcase
  end

  // Sync outranks the handshake, so it restarts the phase even when stalled.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      phase  <= '0;
      data_o <= '0;
    end else if (load_zero || advance) begin
      phase  <= wave_phase;
      data_o <= sample;
    end
  end

endmodule

// File: tb/tb_wave_osc.sv
// Self-checking bench for wave_osc: cycle-by-cycle reference model plus directed literal checks.
module tb_wave_osc;

  localparam int W  = 12;
  localparam int PW = 24;
  localparam int L  = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [PW-1:0] freq;
  logic [1:0]    mode;
  logic          sync;
  logic          ready;
  logic [W-1:0]  data;
  logic          valid;
`ifdef WAVE_OSC_PWM_EN
  logic [W-1:0]  pw = 12'd2048;
`endif

  int tests  = 0;
  int errors = 0;

  int unsigned m_phase = 0;
  int          m_data  = 0;
  bit          m_valid = 1'b0;

  wave_osc #(.width_p(W), .phase_width_p(PW), .lut_log2_p(L)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .freq_i  (freq),
    .mode_i  (mode),
    .sync_i  (sync),
    .ready_i (ready),
`ifdef WAVE_OSC_PWM_EN
    .pw_i    (pw),
`endif
    .data_o  (data),
    .valid_o (valid)
  );

  always #5 clk = ~clk;

  function automatic int wave(input int unsigned ph, input int md);
    int unsigned top;
    int unsigned uu;
    real         s;
    top = ph >> (PW - W);
    case (md)
      0: return int'(top) - 2048;
`ifdef WAVE_OSC_PWM_EN
      1: return (top < pw) ? 2047 : -2048;
`else
      1: return (ph < 32'h80_0000) ? 2047 : -2048;
`endif
      2: begin
        uu = (ph >> (PW - W - 1)) & 32'hFFF;
        if (ph >= 32'h80_0000) uu = 4095 - uu;
        return int'(uu) - 2048;
      end
      default: begin
        s = 2047.0 * $sin(2.0 * 3.14159265358979323846 * real'(ph >> (PW - L)) / 256.0);
        return (s >= 0.0) ? $rtoi(s + 0.5) : $rtoi(s - 0.5);
      end
    endcase
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_phase = 0;
      m_data  = 0;
      m_valid = 1'b0;
    end else if (sync || !m_valid) begin
      m_phase = 0;
      m_data  = wave(0, int'(mode));
      m_valid = 1'b1;
    end else if (ready) begin
      m_phase = (m_phase + freq) & 32'hFF_FFFF;
      m_data  = wave(m_phase, int'(mode));
    end
  end

  always @(negedge clk) begin
    int act;
    act = int'($signed(data));
    tests++;
    if (valid !== m_valid || act != m_data) begin
      errors++;
      $display("FAIL model: valid=%0b data=%0d, expected valid=%0b data=%0d at %0t",
               valid, act, m_valid, m_data, $time);
    end
  end

  task automatic check_lit(input string name, input int exp_data, input bit exp_valid);
    int act;
    @(negedge clk);
    act = int'($signed(data));
    tests++;
    if (valid !== exp_valid || act != exp_data) begin
      errors++;
      $display("FAIL %s: valid=%0b data=%0d, expected valid=%0b data=%0d",
               name, valid, act, exp_valid, exp_data);
    end
  endtask

  int tri_exp[8] = '{-1024, 0, 1024, 2047, 1023, -1, -1025, -2048};
  int sq_exp[8]  = '{2047, 2047, 2047, -2048, -2048, -2048, -2048, 2047};
  int sin_exp[5] = '{2047, 0, -2047, 0, 2047};

  initial begin
    reset = 1'b1; sync = 1'b0; ready = 1'b1; mode = 2'd0; freq = '0;
    repeat (3) check_lit("reset", 0, 1'b0);

    reset = 1'b0; mode = 2'd0; freq = 24'h10_0000;
    check_lit("release", -2048, 1'b1);
    for (int k = 1; k <= 16; k++) check_lit("saw", (k % 16) * 256 - 2048, 1'b1);
    for (int k = 1; k <= 3; k++) check_lit("saw_pre_stall", k * 256 - 2048, 1'b1);

    ready = 1'b0; freq = 24'h20_0000; mode = 2'd2;
    repeat (5) check_lit("stall_hold", -1280, 1'b1);
    ready = 1'b1;
    check_lit("stall_resume_tri", 512, 1'b1);

    sync = 1'b1; mode = 2'd2; freq = 24'h20_0000;
    check_lit("tri_sync", -2048, 1'b1);
    sync = 1'b0;
    for (int k = 0; k < 8; k++) check_lit("tri", tri_exp[k], 1'b1);
    freq = '0;
    repeat (2) check_lit("freq_zero", -2048, 1'b1);

    sync = 1'b1; mode = 2'd1; freq = 24'h20_0000;
    check_lit("sq_sync", 2047, 1'b1);
    sync = 1'b0;
    for (int k = 0; k < 8; k++) check_lit("square", sq_exp[k], 1'b1);

    sync = 1'b1; mode = 2'd3; freq = 24'h40_0000;
    check_lit("sine_sync", 0, 1'b1);
    sync = 1'b0;
    for (int k = 0; k < 5; k++) check_lit("sine", sin_exp[k], 1'b1);

    sync = 1'b1; mode = 2'd0; freq = 24'h10_0000;
    check_lit("saw_sync", -2048, 1'b1);
    sync = 1'b0;
    for (int k = 1; k <= 9; k++) check_lit("saw_to_9", k * 256 - 2048, 1'b1);
    ready = 1'b0; sync = 1'b1;
    check_lit("sync_stalled", -2048, 1'b1);
    sync = 1'b0; ready = 1'b1;
    check_lit("after_sync", -1792, 1'b1);
    check_lit("after_sync2", -1536, 1'b1);

    reset = 1'b1; sync = 1'b1;
    check_lit("reset_over_sync", 0, 1'b0);
    reset = 1'b0; sync = 1'b0;
    check_lit("rerelease", -2048, 1'b1);
    check_lit("rerelease2", -1792, 1'b1);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
